// File: rtl/vedic_seq16x16.sv
// Sequential 16x16 unsigned multiplier built around one 8x8 Vedic core.
// The operands are split into bytes and one byte product is accumulated per
// cycle, over four MUL cycles, into a 32-bit result.

// 2x2 Vedic cell: vertical/crosswise partial products with half adders.
module vedic_2x2 (
    input  logic [1:0] a,
    input  logic [1:0] b,
    output logic [3:0] p
);
    logic x0, x1, c;
    assign x0   = a[1] & b[0];
    assign x1   = a[0] & b[1];
    assign c    = x0 & x1;
    assign p[0] = a[0] & b[0];
    assign p[1] = x0 ^ x1;
    assign p[2] = (a[1] & b[1]) ^ c;
    assign p[3] = (a[1] & b[1]) & c;
endmodule

// 4x4 Vedic block: four 2x2 cells, combined as shifted partial sums.
module vedic_4x4 (
    input  logic [3:0] a,
    input  logic [3:0] b,
    output logic [7:0] p
);
    logic [3:0] q0, q1, q2, q3;
    vedic_2x2 u0 (.a(a[1:0]), .b(b[1:0]), .p(q0));
    vedic_2x2 u1 (.a(a[3:2]), .b(b[1:0]), .p(q1));
    vedic_2x2 u2 (.a(a[1:0]), .b(b[3:2]), .p(q2));
    vedic_2x2 u3 (.a(a[3:2]), .b(b[3:2]), .p(q3));
    assign p = {4'b0, q0} + {2'b0, q1, 2'b0} + {2'b0, q2, 2'b0} + {q3, 4'b0};
endmodule

// 8x8 Vedic core: four 4x4 blocks, combined the same way.
module vedic_8x8 (
    input  logic [7:0]  a,
    input  logic [7:0]  b,
    output logic [15:0] p
);
    logic [7:0] q0, q1, q2, q3;
    vedic_4x4 u0 (.a(a[3:0]), .b(b[3:0]), .p(q0));
    vedic_4x4 u1 (.a(a[7:4]), .b(b[3:0]), .p(q1));
    vedic_4x4 u2 (.a(a[3:0]), .b(b[7:4]), .p(q2));
    vedic_4x4 u3 (.a(a[7:4]), .b(b[7:4]), .p(q3));
    assign p = {8'b0, q0} + {4'b0, q1, 4'b0} + {4'b0, q2, 4'b0} + {q3, 8'b0};
endmodule

module vedic_seq16x16 (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [15:0] a,
    input  logic [15:0] b,
    input  logic        in_valid,
    output logic        in_ready,
    output logic [31:0] y,
    output logic        out_valid,
    input  logic        out_ready
);
    typedef enum logic [1:0] {IDLE, MUL, DONE} state_t;

    state_t      state, state_nx;
    logic [1:0]  step;
    logic [15:0] ra, rb;
    logic [31:0] acc;
    logic [7:0]  core_a, core_b;
    logic [15:0] p;
    logic [31:0] addend;

    // Pick the byte pair for this step; both cross terms carry weight 2^8.
    always_comb begin
        core_a = step[0] ? ra[15:8] : ra[7:0];
        core_b = step[1] ? rb[15:8] : rb[7:0];
        case (step)
            2'd0:    addend = {16'b0, p};
            2'd3:    addend = {p, 16'b0};
            default: addend = {8'b0, p, 8'b0};
        endcase
    end

    vedic_8x8 u_core (.a(core_a), .b(core_b), .p(p));

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nx;
    end

    // Next state and handshake outputs; both depend on state only.
    always_comb begin
        state_nx  = state;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        case (state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) state_nx = MUL;
            end
            MUL:  if (step == 2'd3) state_nx = DONE;
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    // Operand capture, step counter and accumulator; acc is held in DONE/IDLE.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ra   <= '0;
            rb   <= '0;
            acc  <= '0;
            step <= '0;
        end else begin
            case (state)
                IDLE: if (in_valid) begin
                    ra   <= a;
                    rb   <= b;
                    acc  <= '0;
                    step <= '0;
                end
                MUL: begin
                    acc  <= acc + addend;
                    step <= step + 2'd1;
                end
                default: ;
            endcase
        end
    end

    assign y = acc;
endmodule

// File: tb/tb_vedic_seq16x16.sv
// Directed bench for vedic_seq16x16: reset, products, backpressure,
// mid-operation reset and a random back-to-back stream against a*b.
module tb_vedic_seq16x16;
    logic        clk = 1'b0;
    logic        rst_n;
    logic [15:0] a, b;
    logic        in_valid, in_ready;
    logic [31:0] y;
    logic        out_valid, out_ready;

    int pass_cnt = 0;
    int chk_cnt  = 0;

    vedic_seq16x16 dut (
        .clk(clk), .rst_n(rst_n), .a(a), .b(b), .in_valid(in_valid),
        .in_ready(in_ready), .y(y), .out_valid(out_valid), .out_ready(out_ready)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        chk_cnt++;
        assert (obs === exp) pass_cnt++;
        else $error("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    endtask

    // One product with out_ready high: latency, value, release to IDLE.
    task automatic do_mul(input string tag, input logic [15:0] av, input logic [15:0] bv,
                          input logic [31:0] ev);
        int n;
        n = 0;
        while (!in_ready && n < 20) begin tick(); n++; end
        check({tag, " ready"}, {31'b0, in_ready}, 32'd1);
        a = av; b = bv; in_valid = 1'b1; out_ready = 1'b1;
        tick();
        in_valid = 1'b0;
        n = 0;
        while (!out_valid && n < 20) begin tick(); n++; end
        check({tag, " latency"}, n, 32'd4);
        check({tag, " y"}, y, ev);
        tick();
        check({tag, " ov drop"}, {31'b0, out_valid}, 32'd0);
        check({tag, " ir back"}, {31'b0, in_ready}, 32'd1);
    endtask

    initial begin
        logic [31:0] exp_q[$];
        logic [31:0] ev;
        int n, seen, sent, rec;

        rst_n = 1'b0; a = '0; b = '0; in_valid = 1'b0; out_ready = 1'b0;
        #12;
        check("rst y", y, 32'd0);
        check("rst ov", {31'b0, out_valid}, 32'd0);
        rst_n = 1'b1;
        tick();
        check("rst ir", {31'b0, in_ready}, 32'd1);

        do_mul("basic", 16'h1234, 16'h5678, 32'h0626_0060);
        do_mul("max",   16'hFFFF, 16'hFFFF, 32'hFFFE_0001);
        do_mul("zero",  16'h0000, 16'hBEEF, 32'h0000_0000);
        do_mul("pow",   16'h0100, 16'h0100, 32'h0001_0000);

        // Backpressure: hold DONE for 7 cycles while the inputs churn.
        out_ready = 1'b0;
        a = 16'h00FF; b = 16'hFF00; in_valid = 1'b1;
        tick();
        n = 0;
        while (!out_valid && n < 20) begin
            a = 16'($urandom); b = 16'($urandom); in_valid = 1'($urandom);
            tick(); n++;
        end
        check("bp latency", n, 32'd4);
        for (int i = 0; i < 7; i++) begin
            check("bp y", y, 32'h00FE_0100);
            check("bp ov", {31'b0, out_valid}, 32'd1);
            check("bp ir", {31'b0, in_ready}, 32'd0);
            a = 16'($urandom); b = 16'($urandom); in_valid = 1'($urandom);
            tick();
        end
        check("bp y end", y, 32'h00FE_0100);
        in_valid = 1'b0; out_ready = 1'b1;
        tick();
        check("bp ov drop", {31'b0, out_valid}, 32'd0);

        // Reset during step 2.
        a = 16'h1234; b = 16'h5678; in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        tick(); tick();
        rst_n = 1'b0;
        #1;
        check("mid y", y, 32'd0);
        check("mid ov", {31'b0, out_valid}, 32'd0);
        #1;
        rst_n = 1'b1;
        check("mid ir", {31'b0, in_ready}, 32'd1);
        seen = 0;
        for (int i = 0; i < 6; i++) begin
            tick();
            if (out_valid) seen++;
        end
        check("mid no ov", seen, 32'd0);
        do_mul("post rst", 16'd3, 16'd5, 32'd15);

        // Back-to-back stream with random consumer stalls.
        sent = 0; rec = 0; n = 0;
        in_valid = 1'b1;
        while (rec < 100 && n < 3000) begin
            a = 16'($urandom); b = 16'($urandom); out_ready = 1'($urandom);
            if (in_ready && sent < 100) begin
                exp_q.push_back(32'(a) * 32'(b));
                sent++;
            end
            if (out_valid && out_ready) begin
                if (exp_q.size() > 0) begin
                    ev = exp_q.pop_front();
                    check("stream y", y, ev);
                end else begin
                    check("stream extra", 32'd1, 32'd0);
                end
                rec++;
            end
            tick(); n++;
        end
        in_valid = 1'b0;
        check("stream count", rec, 32'd100);
        check("stream left", exp_q.size(), 32'd0);

        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end
endmodule
